// File: rtl/motion_highlight.sv
// rtl/motion_highlight.sv - recolours motion pixels and counts them per frame; optional HIGHLIGHT_BLEND_EN blends instead of replacing
module motion_highlight #(
  parameter int          WIDTH    = 720,
  parameter int          HEIGHT   = 540,
  parameter logic [23:0] HL_COLOR = 24'hFF0000,
  parameter int          CNT_W    = 20
) (
  input  logic             clock,
  input  logic             reset,
  output logic             mask_rd_en,
  input  logic             mask_empty,
  input  logic [7:0]       mask_dout,
  output logic             img_rd_en,
  input  logic             img_empty,
  input  logic [23:0]      img_dout,
  output logic             img_out_wr_en,
  input  logic             img_out_full,
  output logic [23:0]      img_out_din,
  output logic [CNT_W-1:0] motion_count,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(WIDTH * HEIGHT - 1);

  typedef enum logic {S_READ = 1'b0, S_WRITE = 1'b1} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [23:0]      r_out_pix;
  logic [CNT_W-1:0] r_pixel_cnt;
  logic [CNT_W-1:0] r_motion_acc;
  logic [CNT_W-1:0] r_motion_count;
  logic             r_frame_done;
  logic             w_pop;
  logic             w_push;
  logic             w_motion;
  logic [23:0]      w_hl_pix;

  assign w_motion     = (mask_dout == 8'h00);
  assign motion_count = r_motion_count;
  assign frame_done   = r_frame_done;

`ifdef HIGHLIGHT_BLEND_EN
  // Motion pixel is the per-channel average of the source pixel and the highlight colour.
  always_comb begin
    w_hl_pix[23:16] = 8'(({1'b0, img_dout[23:16]} + {1'b0, HL_COLOR[23:16]}) >> 1);
    w_hl_pix[15:8]  = 8'(({1'b0, img_dout[15:8]}  + {1'b0, HL_COLOR[15:8]})  >> 1);
    w_hl_pix[7:0]   = 8'(({1'b0, img_dout[7:0]}   + {1'b0, HL_COLOR[7:0]})   >> 1);
  end
`else
  assign w_hl_pix = HL_COLOR;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_READ;
    else       r_state <= w_next_state;
  end

  // Next state and FIFO handshakes; both inputs pop together or not at all.
  always_comb begin
    w_next_state  = S_READ;
    mask_rd_en    = 1'b0;
    img_rd_en     = 1'b0;
    img_out_wr_en = 1'b0;
    img_out_din   = 24'h0;
    w_pop         = 1'b0;
    w_push        = 1'b0;
    case (r_state)
      S_READ: begin
        w_next_state = S_READ;
        if (!mask_empty && !img_empty) begin
          w_pop        = 1'b1;
          mask_rd_en   = 1'b1;
          img_rd_en    = 1'b1;
          w_next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        w_next_state = S_WRITE;
        if (!img_out_full) begin
          w_push        = 1'b1;
          img_out_wr_en = 1'b1;
          img_out_din   = r_out_pix;
          w_next_state  = S_READ;
        end
      end
      default: w_next_state = S_READ;
    endcase
  end

  // Pixel capture, motion accumulation and end-of-frame publication.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_pix      <= 24'h0;
      r_pixel_cnt    <= '0;
      r_motion_acc   <= '0;
      r_motion_count <= '0;
      r_frame_done   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_pop) begin
        r_out_pix <= w_motion ? w_hl_pix : img_dout;
        if (w_motion) r_motion_acc <= r_motion_acc + 1'b1;
      end
      // The final pixel's motion was already added on its pop cycle, so the
      // accumulator is complete by the time its write handshake arrives.
      if (w_push) begin
        if (r_pixel_cnt == LAST_PIX) begin
          r_motion_count <= r_motion_acc;
          r_frame_done   <= 1'b1;
          r_pixel_cnt    <= '0;
          r_motion_acc   <= '0;
        end else begin
          r_pixel_cnt <= r_pixel_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_motion_highlight.sv
// tb/tb_motion_highlight.sv - scoreboard bench for motion_highlight with FWFT FIFO models
module tb_motion_highlight;
  localparam int          W  = 4;
  localparam int          H  = 2;
  localparam int          N  = W * H;
  localparam int          CW = 20;
  localparam logic [23:0] HL = 24'hFF0000;

  logic          clock = 1'b0;
  logic          reset;
  logic          mask_rd_en, mask_empty;
  logic [7:0]    mask_dout;
  logic          img_rd_en, img_empty;
  logic [23:0]   img_dout;
  logic          img_out_wr_en, img_out_full;
  logic [23:0]   img_out_din;
  logic [CW-1:0] motion_count;
  logic          frame_done;

  motion_highlight #(.WIDTH(W), .HEIGHT(H), .HL_COLOR(HL), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .mask_rd_en(mask_rd_en), .mask_empty(mask_empty), .mask_dout(mask_dout),
    .img_rd_en(img_rd_en), .img_empty(img_empty), .img_dout(img_dout),
    .img_out_wr_en(img_out_wr_en), .img_out_full(img_out_full), .img_out_din(img_out_din),
    .motion_count(motion_count), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  logic [7:0]    mq[$];
  logic [23:0]   iq[$];
  logic [23:0]   exp_pix[$];
  logic [CW-1:0] exp_cnt[$];
  bit            mask_hold, img_hold, rand_full;
  int            tests, fails;
  int            writes_seen, frames_seen, frames_expected;
  int            model_idx, model_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [23:0] model_pix(input logic [7:0] m, input logic [23:0] p);
    int r, g, b;
    if (m != 8'h00) return p;
`ifdef HIGHLIGHT_BLEND_EN
    r = (((p >> 16) & 255) + ((HL >> 16) & 255)) / 2;
    g = (((p >> 8) & 255) + ((HL >> 8) & 255)) / 2;
    b = ((p & 255) + (HL & 255)) / 2;
    return {r[7:0], g[7:0], b[7:0]};
`else
    return HL;
`endif
  endfunction

  function automatic void update_inputs();
    mask_empty = mask_hold || (mq.size() == 0);
    img_empty  = img_hold || (iq.size() == 0);
    mask_dout  = (mq.size() != 0) ? mq[0] : 8'h00;
    img_dout   = (iq.size() != 0) ? iq[0] : 24'h0;
  endfunction

  task automatic push_exp(input logic [7:0] m, input logic [23:0] p, input logic [23:0] e);
    mq.push_back(m);
    iq.push_back(p);
    exp_pix.push_back(e);
    if (m == 8'h00) model_acc++;
    model_idx++;
    if (model_idx == N) begin
      exp_cnt.push_back(CW'(model_acc));
      frames_expected++;
      model_idx = 0;
      model_acc = 0;
    end
    update_inputs();
  endtask

  task automatic push_pix(input logic [7:0] m, input logic [23:0] p);
    push_exp(m, p, model_pix(m, p));
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_pix.size() != 0 || exp_cnt.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    tick();
    check({name, "_drain_timeout"}, (n >= 2000) ? 1 : 0, 0);
  endtask

  task automatic wait_writes(input int target);
    int n = 0;
    while (writes_seen < target && n < 500) begin
      tick();
      n++;
    end
    check("wait_writes_timeout", (n >= 500) ? 1 : 0, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_mask_rd_en"}, mask_rd_en, 0);
    check({name, "_img_rd_en"}, img_rd_en, 0);
    check({name, "_wr_en"}, img_out_wr_en, 0);
    check({name, "_din"}, img_out_din, 0);
    check({name, "_motion_count"}, motion_count, 0);
    check({name, "_frame_done"}, frame_done, 0);
  endtask

  // FIFO model: pops requested in a cycle take effect just after its rising edge.
  initial begin
    logic pm, pi;
    forever begin
      @(negedge clock);
      pm = mask_rd_en;
      pi = img_rd_en;
      @(posedge clock);
      #1;
      if (!reset) begin
        if (pm) begin
          if (mq.size() == 0) check("mask_pop_on_empty", 1, 0);
          else void'(mq.pop_front());
        end
        if (pi) begin
          if (iq.size() == 0) check("img_pop_on_empty", 1, 0);
          else void'(iq.pop_front());
        end
      end
      update_inputs();
    end
  end

  // Random output back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clock);
      #2;
      if (rand_full) img_out_full = ($urandom_range(0, 2) == 0);
    end
  end

  // Monitor: compares every output handshake and frame pulse with the scoreboard.
  initial begin
    logic [23:0]   ep;
    logic [CW-1:0] ec;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (mask_rd_en !== img_rd_en) check("pop_pairing", {31'b0, mask_rd_en}, {31'b0, img_rd_en});
        if (img_out_wr_en) begin
          writes_seen++;
          if (exp_pix.size() == 0) check("unexpected_write", 1, 0);
          else begin
            ep = exp_pix.pop_front();
            check("pixel", img_out_din, ep);
          end
        end else if (img_out_din !== 24'h0) begin
          check("din_idle_zero", img_out_din, 0);
        end
        if (frame_done) begin
          frames_seen++;
          if (exp_cnt.size() == 0) check("unexpected_frame_done", 1, 0);
          else begin
            ec = exp_cnt.pop_front();
            check("motion_count", motion_count, ec);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] pat [8];
    int base;
    pat = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
    reset = 1'b1;
    img_out_full = 1'b0;
    update_inputs();
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // All static: output mirrors input, count zero, one frame pulse.
    for (int i = 1; i <= N; i++) push_pix(8'hFF, 24'(i));
    drain("static");
    check("static_motion_count", motion_count, 0);
    check("static_frames", frames_seen, 1);

    // Fixed motion pattern.
    for (int i = 0; i < N; i++) push_pix(pat[i], 24'h123456);
    drain("pattern");
    check("pattern_motion_count", motion_count, 4);
    check("pattern_frames", frames_seen, 2);

    // Back-pressure for 10 cycles mid-frame.
    base = writes_seen;
    for (int i = 0; i < N; i++) push_pix(($urandom_range(0, 1) != 0) ? 8'h00 : 8'h5A, 24'($urandom));
    wait_writes(base + 3);
    img_out_full = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("stall_no_pop", {31'b0, mask_rd_en | img_rd_en}, 0);
      check("stall_no_write", img_out_wr_en, 0);
    end
    tick();
    img_out_full = 1'b0;
    drain("stall");

    // Image FIFO empty while mask FIFO holds data.
    img_hold = 1'b1;
    for (int i = 0; i < N; i++) push_pix(8'($urandom_range(0, 1)), 24'($urandom));
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("skew_no_mask_pop", mask_rd_en, 0);
    end
    tick();
    img_hold = 1'b0;
    update_inputs();
    @(negedge clock);
    check("skew_joint_pop", {30'b0, mask_rd_en, img_rd_en}, 3);
    drain("skew");

    // Random frames under random back-pressure.
    rand_full = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < N; i++)
        push_pix(($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(1, 255)), 24'($urandom));
    drain("random");
    rand_full = 1'b0;
    img_out_full = 1'b0;
    check("frames_total", frames_seen, frames_expected);

    // Reset after 3 of 8 pixels discards the partial frame.
    base = writes_seen;
    for (int i = 0; i < N; i++) push_pix(8'h00, 24'($urandom));
    wait_writes(base + 3);
    reset = 1'b1;
    mq.delete(); iq.delete(); exp_pix.delete(); exp_cnt.delete();
    model_idx = 0;
    model_acc = 0;
    update_inputs();
    tick();
    check_reset_outputs("midreset");
    reset = 1'b0;
    tick();
    for (int i = 0; i < N; i++) push_pix((i < 3) ? 8'h00 : 8'h01, 24'($urandom));
    drain("after_reset");
    check("after_reset_motion_count", motion_count, 3);

`ifdef HIGHLIGHT_BLEND_EN
    push_exp(8'h00, 24'h204060, 24'h8F2030);
    push_exp(8'hFF, 24'h204060, 24'h204060);
    for (int i = 2; i < N; i++) push_pix(8'hFF, 24'($urandom));
    drain("blend");
    check("blend_motion_count", motion_count, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
